decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of instruction, PC and PC+4 paths.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 InstrF  input  32  fetched instruction.
REQ-005 PCF  input  32  PC of InstrF.
REQ-006 PCPlus4F  input  32  PCF+4.
REQ-007 ValidF  input  1  InstrF/PCF carry a real instruction this cycle.
REQ-008 StallD  input  1  hazard unit: hold the IF/ID register.
REQ-009 FlushD  input  1  hazard unit: squash the IF/ID register.
REQ-010 InstrD, PCD, PCPlus4D  output  32 each  registered IF/ID contents.
REQ-011 ValidD  output  1  registered valid bit.
REQ-012 Immediate  output  25  InstrD[31:7], feeds the immediate extender.
REQ-013 ImmSrc  output  3  000=I, 001=S, 010=B, 011=J, 100=U.
REQ-014 Rs1D, Rs2D, RdD  output  5 each  InstrD[19:15], [24:20], [11:7].
REQ-015 Funct3D  output  3  InstrD[14:12]; Funct7b5D  output  1  InstrD[30].
REQ-016 RegWriteD, MemWriteD, BranchD, JumpD, JumpRegD, ALUSrcD, ALUSrcAPCD  output  1 each  control flags.
REQ-017 ResultSrcD  output  2  00=ALU, 01=memory, 10=PC+4, 11=immediate.
REQ-018 ALUOpD  output  2  00=add, 01=branch compare, 10=use funct fields.
REQ-019 IllegalD  output  1  valid instruction with an unsupported opcode.

Function
REQ-020 The IF/ID register (InstrD, PCD, PCPlus4D, ValidD) SHALL update on every rising clk edge; priority: rst > FlushD > StallD > load.
REQ-021 Load: InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCPlus4F, ValidD<=ValidF; latency exactly 1 cycle from F inputs to D outputs.
REQ-022 StallD=1, FlushD=0: all four registers SHALL hold their values.
REQ-023 FlushD=1 (stall ignored): InstrD<=32'h00000013, ValidD<=0, PCD and PCPlus4D <= 0.
REQ-024 ValidF=0 on load: InstrD<=32'h00000013 regardless of InstrF; PCD/PCPlus4D are loaded.
REQ-025 All decoded outputs SHALL be combinational from InstrD and ValidD only; no combinational path from any F input to any D output.
REQ-026 Decode by InstrD[6:0]; flags not listed are 0, ResultSrc=00, ALUOp=00, ImmSrc=000:
 - 0110011 R: RegWrite, ALUOp=10.
 - 0010011 I-ALU: RegWrite, ALUSrc, ALUOp=10.
 - 0000011 load: RegWrite, ALUSrc, ResultSrc=01.
 - 0100011 store: MemWrite, ALUSrc, ImmSrc=001.
 - 1100011 branch: Branch, ALUOp=01, ImmSrc=010.
 - 1101111 JAL: RegWrite, Jump, ResultSrc=10, ImmSrc=011.
 - 1100111 JALR: RegWrite, Jump, JumpReg, ALUSrc, ResultSrc=10.
 - 0110111 LUI: RegWrite, ResultSrc=11, ImmSrc=100.
 - 0010111 AUIPC: RegWrite, ALUSrc, ALUSrcAPC, ImmSrc=100.
REQ-027 Any other opcode with ValidD=1: IllegalD=1 and every control flag 0.
REQ-028 ValidD=0: RegWrite, MemWrite, Branch, Jump, JumpReg and IllegalD SHALL be 0, whatever InstrD holds.
REQ-029 Field outputs (Immediate, Rs1D, Rs2D, RdD, Funct3D, Funct7b5D) SHALL be raw slices of InstrD, never masked.
REQ-030 A write to x0 (RdD=0) SHALL still assert RegWriteD; the register file discards it.

Reset
REQ-031 rst=1 at a clock edge: InstrD=32'h00000013, PCD=0, PCPlus4D=0, ValidD=0 on the next cycle; all side-effect flags 0.
REQ-032 rst SHALL take priority over FlushD and StallD; rst asserted mid-stall SHALL discard the held instruction.

Verification
REQ-033 Load InstrF=32'h00500093 (addi x1,x0,5), ValidF=1 -> next cycle RegWriteD=1, ALUSrcD=1, ImmSrc=000, RdD=1, Immediate=InstrF[31:7].
REQ-034 InstrF=32'hFE208EE3 (beq) -> BranchD=1, ALUOpD=01, ImmSrc=010, RegWriteD=0, MemWriteD=0.
REQ-035 Load a sw, then StallD=1 for 3 cycles with different InstrF each cycle -> InstrD, PCD and MemWriteD=1 stay unchanged throughout.
REQ-036 StallD=1 and FlushD=1 together, holding a JAL -> next cycle InstrD=32'h00000013, ValidD=0, JumpD=0.
REQ-037 InstrF=32'h0000007F, ValidF=1 -> IllegalD=1, all flags 0. Same word with ValidF=0 -> IllegalD=0, InstrD=NOP.
REQ-038 rst asserted during a stall holding LUI (32'h123450B7) -> next cycle ValidD=0, InstrD=NOP. After rst is released, loading the LUI again gives ResultSrcD=11, ImmSrc=100.

Source files
------------

// File: rtl/decode_stage.sv
// IF/ID pipeline register plus main control decoder for an RV32I-style five-stage core.
// Decoded outputs depend only on the registered instruction and valid bit.
module decode_stage #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] InstrF,
  input  logic [DATA_WIDTH-1:0] PCF,
  input  logic [DATA_WIDTH-1:0] PCPlus4F,
  input  logic                  ValidF,
  input  logic                  StallD,
  input  logic                  FlushD,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD,
  output logic [24:0]           Immediate,
  output logic [2:0]            ImmSrc,
  output logic [4:0]            Rs1D,
  output logic [4:0]            Rs2D,
  output logic [4:0]            RdD,
  output logic [2:0]            Funct3D,
  output logic                  Funct7b5D,
  output logic                  RegWriteD,
  output logic                  MemWriteD,
  output logic                  BranchD,
  output logic                  JumpD,
  output logic                  JumpRegD,
  output logic                  ALUSrcD,
  output logic                  ALUSrcAPCD,
  output logic [1:0]            ResultSrcD,
  output logic [1:0]            ALUOpD,
  output logic                  IllegalD
);

  localparam logic [DATA_WIDTH-1:0] Nop = DATA_WIDTH'(32'h0000_0013);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpIAlu  = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;

  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic                  valid_q, valid_d;

  // Priority: reset, then flush, then stall, then load.
  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (rst || FlushD) begin
      instr_d    = Nop;
      pc_d       = '0;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (!StallD) begin
      instr_d    = ValidF ? InstrF : Nop;
      pc_d       = PCF;
      pc_plus4_d = PCPlus4F;
      valid_d    = ValidF;
    end
  end

  always_ff @(posedge clk) begin
    instr_q    <= instr_d;
    pc_q       <= pc_d;
    pc_plus4_q <= pc_plus4_d;
    valid_q    <= valid_d;
  end

  assign InstrD    = instr_q;
  assign PCD       = pc_q;
  assign PCPlus4D  = pc_plus4_q;
  assign ValidD    = valid_q;

  assign Immediate = instr_q[31:7];
  assign Rs1D      = instr_q[19:15];
  assign Rs2D      = instr_q[24:20];
  assign RdD       = instr_q[11:7];
  assign Funct3D   = instr_q[14:12];
  assign Funct7b5D = instr_q[30];

  logic reg_write, mem_write, branch, jump, jump_reg, illegal;

  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    jump_reg   = 1'b0;
    illegal    = 1'b0;
    ALUSrcD    = 1'b0;
    ALUSrcAPCD = 1'b0;
    ResultSrcD = 2'b00;
    ALUOpD     = 2'b00;
    ImmSrc     = 3'b000;
    unique case (instr_q[6:0])
      OpR: begin
        reg_write = 1'b1;
        ALUOpD    = 2'b10;
      end
      OpIAlu: begin
        reg_write = 1'b1;
        ALUSrcD   = 1'b1;
        ALUOpD    = 2'b10;
      end
      OpLoad: begin
        reg_write  = 1'b1;
        ALUSrcD    = 1'b1;
        ResultSrcD = 2'b01;
      end
      OpStore: begin
        mem_write = 1'b1;
        ALUSrcD   = 1'b1;
        ImmSrc    = 3'b001;
      end
      OpBr: begin
        branch = 1'b1;
        ALUOpD = 2'b01;
        ImmSrc = 3'b010;
      end
      OpJal: begin
        reg_write  = 1'b1;
        jump       = 1'b1;
        ResultSrcD = 2'b10;
        ImmSrc     = 3'b011;
      end
      OpJalr: begin
        reg_write  = 1'b1;
        jump       = 1'b1;
        jump_reg   = 1'b1;
        ALUSrcD    = 1'b1;
        ResultSrcD = 2'b10;
      end
      OpLui: begin
        reg_write  = 1'b1;
        ResultSrcD = 2'b11;
        ImmSrc     = 3'b100;
      end
      OpAuipc: begin
        reg_write  = 1'b1;
        ALUSrcD    = 1'b1;
        ALUSrcAPCD = 1'b1;
        ImmSrc     = 3'b100;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Side-effect flags are squashed for bubbles so a stale InstrD can never commit.
  assign RegWriteD = reg_write & valid_q;
  assign MemWriteD = mem_write & valid_q;
  assign BranchD   = branch    & valid_q;
  assign JumpD     = jump      & valid_q;
  assign JumpRegD  = jump_reg  & valid_q;
  assign IllegalD  = illegal   & valid_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: a table-driven reference model of the IF/ID register
// and control decode is compared against the DUT every cycle, plus directed scenarios.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        ValidF, StallD, FlushD;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [24:0] Immediate;
  logic [2:0]  ImmSrc;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [2:0]  Funct3D;
  logic        Funct7b5D;
  logic        RegWriteD, MemWriteD, BranchD, JumpD, JumpRegD, ALUSrcD, ALUSrcAPCD;
  logic [1:0]  ResultSrcD, ALUOpD;
  logic        IllegalD;

  decode_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .ValidF(ValidF), .StallD(StallD), .FlushD(FlushD),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .Immediate(Immediate), .ImmSrc(ImmSrc), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .Funct3D(Funct3D), .Funct7b5D(Funct7b5D), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .JumpD(JumpD), .JumpRegD(JumpRegD), .ALUSrcD(ALUSrcD),
    .ALUSrcAPCD(ALUSrcAPCD), .ResultSrcD(ResultSrcD), .ALUOpD(ALUOpD), .IllegalD(IllegalD)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // {opcode, RegWrite MemWrite Branch Jump JumpReg ALUSrc ALUSrcAPC ResultSrc ALUOp ImmSrc}
  localparam logic [20:0] TBL [9] = '{
    {7'b0110011, 14'b1_0_0_0_0_0_0_00_10_000},
    {7'b0010011, 14'b1_0_0_0_0_1_0_00_10_000},
    {7'b0000011, 14'b1_0_0_0_0_1_0_01_00_000},
    {7'b0100011, 14'b0_1_0_0_0_1_0_00_00_001},
    {7'b1100011, 14'b0_0_1_0_0_0_0_00_01_010},
    {7'b1101111, 14'b1_0_0_1_0_0_0_10_00_011},
    {7'b1100111, 14'b1_0_0_1_1_1_0_10_00_000},
    {7'b0110111, 14'b1_0_0_0_0_0_0_11_00_100},
    {7'b0010111, 14'b1_0_0_0_0_1_1_00_00_100}
  };

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_instr, m_pc, m_pc4;
  logic        m_valid;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  // Expected {flags, IllegalD}; unknown opcodes decode to all-zero flags.
  function automatic logic [14:0] exp_ctl(input logic [31:0] ins, input logic v);
    logic [14:0] r;
    r = {14'b0, v};
    for (int i = 0; i < 9; i++)
      if (TBL[i][20:14] == ins[6:0]) r = {TBL[i][13:0], 1'b0};
    if (!v) r = r & ~15'h7C00;
    return r;
  endfunction

  function automatic logic [14:0] dut_ctl();
    return {RegWriteD, MemWriteD, BranchD, JumpD, JumpRegD, ALUSrcD, ALUSrcAPCD,
            ResultSrcD, ALUOpD, ImmSrc, IllegalD};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                       input logic st, input logic fl, input logic r);
    InstrF = ins; PCF = pc; PCPlus4F = pc + 32'd4;
    ValidF = v; StallD = st; FlushD = fl; rst = r;
  endtask

  // Advance one clock, update the model, then compare every output 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (rst || FlushD) begin
      m_instr = NOP; m_pc = '0; m_pc4 = '0; m_valid = 1'b0;
    end else if (!StallD) begin
      m_instr = ValidF ? InstrF : NOP;
      m_pc = PCF; m_pc4 = PCPlus4F; m_valid = ValidF;
    end
    #1;
    check_eq("InstrD", InstrD, m_instr);
    check_eq("PCD", PCD, m_pc);
    check_eq("PCPlus4D", PCPlus4D, m_pc4);
    check_eq("ValidD", ValidD, m_valid);
    check_eq("ctrl", dut_ctl(), exp_ctl(m_instr, m_valid));
    check_eq("fields", {Immediate, Rs1D, Rs2D, RdD, Funct3D, Funct7b5D},
             {m_instr[31:7], m_instr[19:15], m_instr[24:20], m_instr[11:7],
              m_instr[14:12], m_instr[30]});
  endtask

  initial begin
    logic [31:0] ins;
    drive(32'hDEAD_BEEF, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    check_eq("rst_instr", InstrD, NOP);
    check_eq("rst_valid", ValidD, 0);
    check_eq("rst_regwrite", RegWriteD, 0);

    // addi x1,x0,5
    drive(32'h0050_0093, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    check_eq("addi_flags", {RegWriteD, ALUSrcD, ImmSrc}, {1'b1, 1'b1, 3'b000});
    check_eq("addi_rd", RdD, 5'd1);
    check_eq("addi_imm", Immediate, 25'(32'h0050_0093 >> 7));

    // beq
    drive(32'hFE20_8EE3, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    check_eq("beq_flags", {BranchD, ALUOpD, ImmSrc, RegWriteD, MemWriteD},
             {1'b1, 2'b01, 3'b010, 1'b0, 1'b0});

    // sw x1,0(x2) then three stalled cycles with changing fetch
    drive(32'h0011_2023, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle();
      check_eq("stall_instr", InstrD, 32'h0011_2023);
      check_eq("stall_pc", PCD, 32'h200);
      check_eq("stall_memwrite", MemWriteD, 1);
    end

    // JAL held, then stall+flush together
    drive(32'h0080_00EF, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    check_eq("jal_jump", JumpD, 1);
    drive(32'h0000_0033, 32'h304, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle();
    check_eq("flush_instr", InstrD, NOP);
    check_eq("flush_valid_jump", {ValidD, JumpD}, 2'b00);

    // unsupported opcode, valid then invalid
    drive(32'h0000_007F, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    check_eq("illegal_valid", dut_ctl(), 15'h0001);
    drive(32'h0000_007F, 32'h404, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    check_eq("illegal_invalid", IllegalD, 0);
    check_eq("invalid_nop", InstrD, NOP);

    // reset during a stall holding LUI, then reload
    drive(32'h1234_50B7, 32'h500, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    drive($urandom, 32'h504, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    check_eq("lui_held", InstrD, 32'h1234_50B7);
    drive($urandom, 32'h508, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle();
    check_eq("rst_stall", {ValidD, InstrD}, {1'b0, NOP});
    drive(32'h1234_50B7, 32'h500, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    check_eq("lui_reload", {ResultSrcD, ImmSrc}, {2'b11, 3'b100});

    // random traffic, including x0 destinations and unsupported opcodes
    for (int n = 0; n < 2000; n++) begin
      ins = $urandom;
      if ($urandom_range(99) < 85) ins[6:0] = TBL[$urandom_range(8)][20:14];
      if ($urandom_range(9) == 0) ins[11:7] = 5'd0;
      drive(ins, $urandom, $urandom_range(99) < 80, $urandom_range(99) < 25,
            $urandom_range(99) < 10, $urandom_range(99) < 2);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
